// File: rtl/i2s_receiver.sv
// i2s_receiver: oversampling I2S receiver. Synchronises sclk/lrclk/sd into
// clk, deserialises MSB-first words using the I2S one-bit delay, and publishes
// one left/right pair per frame with a single-cycle valid strobe.
// Optional build macro I2S_RX_ERRCNT_EN enables the saturating err_count
// counter; without it err_count is tied to zero.
module i2s_receiver #(
  parameter int WIDTH       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sclk,
  input  logic             lrclk,
  input  logic             sd,
  output logic [WIDTH-1:0] left_data,
  output logic [WIDTH-1:0] right_data,
  output logic             valid,
  output logic             frame_err,
  output logic [15:0]      err_count
);

  // Counter must hold WIDTH+1 (saturation point).
  localparam int             CW       = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]  CNT_SAT  = CW'(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {ALIGN, LEFT, RIGHT} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sclk_sync, lr_sync, sd_sync;
  logic                   sclk_prev;
  logic                   sclk_s, lr_s, sd_s;
  logic                   lr_prev;
  logic                   bit_evt, boundary, n_bad;
  logic [CW-1:0]          cnt;
  logic [WIDTH-1:0]       shreg, word_done, bit_mask, left_hold;
  logic                   ld_hold, publish, err;

  // Synchronisers and edge history. Deliberately not reset: clearing them
  // while sclk is high would fabricate a rising edge after reset release.
  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
    lr_sync   <= {lr_sync[SYNC_STAGES-2:0], lrclk};
    sd_sync   <= {sd_sync[SYNC_STAGES-2:0], sd};
    sclk_prev <= sclk_sync[SYNC_STAGES-1];
  end

  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign lr_s     = lr_sync[SYNC_STAGES-1];
  assign sd_s     = sd_sync[SYNC_STAGES-1];
  assign bit_evt  = sclk_s & ~sclk_prev;
  assign boundary = bit_evt & (lr_s != lr_prev);
  // cnt bits precede the boundary bit, so N = cnt+1.
  assign n_bad    = (cnt != CNT_LAST);

  // Word as it stands including the current bit; the mask walks off the
  // bottom once WIDTH bits are in, which drops any surplus bits for free.
  always_comb begin
    bit_mask  = {1'b1, {(WIDTH-1){1'b0}}} >> cnt;
    word_done = sd_s ? (shreg | bit_mask) : shreg;
  end

  // Shift register, bit counter and previous word-select sample.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lr_prev <= 1'b0;
      shreg   <= '0;
      cnt     <= '0;
    end else if (bit_evt) begin
      lr_prev <= lr_s;
      if (lr_s != lr_prev) begin
        shreg <= '0;
        cnt   <= '0;
      end else begin
        shreg <= word_done;
        if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
      end
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= ALIGN;
    else       state <= state_n;
  end

  // Next-state and boundary actions; ALIGN only waits for a right->left edge.
  always_comb begin
    state_n = state;
    ld_hold = 1'b0;
    publish = 1'b0;
    err     = 1'b0;
    if (boundary) begin
      case (state)
        ALIGN: if (!lr_s) state_n = LEFT;
        LEFT: if (lr_s) begin
          ld_hold = 1'b1;
          err     = n_bad;
          state_n = RIGHT;
        end
        RIGHT: if (!lr_s) begin
          publish = 1'b1;
          err     = n_bad;
          state_n = LEFT;
        end
        default: state_n = ALIGN;
      endcase
    end
  end

  // Output registers: left hold, published pair and strobes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      left_hold  <= '0;
      left_data  <= '0;
      right_data <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid     <= publish;
      frame_err <= err;
      if (ld_hold) left_hold <= word_done;
      if (publish) begin
        left_data  <= left_hold;
        right_data <= word_done;
      end
    end
  end

`ifdef I2S_RX_ERRCNT_EN
  // Saturating frame-error counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rstn)                            err_count <= '0;
    else if (frame_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: directed I2S streams against a word-level model.
module tb_i2s_receiver;
  localparam int W = 24;
  localparam int S = 2;

  logic clk = 0, rstn = 0, sclk = 0, lrclk = 0, sd = 0;
  logic [W-1:0] left_data, right_data;
  logic valid, frame_err;
  logic [15:0] err_count;

  i2s_receiver #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .rstn(rstn), .sclk(sclk), .lrclk(lrclk), .sd(sd),
    .left_data(left_data), .right_data(right_data), .valid(valid),
    .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] l; logic [W-1:0] r; int c; } pair_t;

  int total = 0, bad = 0, cyc = 0;
  int last_rise = 0, m_err = 0, fe_seen = 0;
  bit m_aligned = 0, bb_mode = 0, rst_q = 0, pv = 0;
  logic [W-1:0] m_hold = 0, pl = 0, pr = 0;
  pair_t exp_q[$], obs_q[$];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= !rstn;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Left-justify an n-bit MSB-first word into W bits.
  function automatic logic [W-1:0] just(input logic [63:0] v, input int n);
    if (n >= W) return W'(v >> (n - W));
    return W'(v << (W - n));
  endfunction

  // Per-cycle observer: records publishes, checks strobe and hold rules.
  always @(negedge clk) begin
    if (valid) begin
      obs_q.push_back('{left_data, right_data, cyc});
      if (pv) check("valid_back_to_back", {63'd0, pv & valid}, 64'd0);
    end else if (!rst_q) begin
      check("hold_left", left_data, pl);
      check("hold_right", right_data, pr);
    end
    if (frame_err) fe_seen++;
    pl = left_data;
    pr = right_data;
    pv = valid;
  end

  // One sclk period of 8 clk; lrclk/sd change on the falling edge.
  task automatic send_bit(input bit lr, input bit b);
    @(negedge clk);
    sclk = 0; lrclk = lr; sd = b;
    repeat (4) @(negedge clk);
    sclk = 1;
    last_rise = cyc;
    repeat (3) @(negedge clk);
  endtask

  // Word-level model of what a completed channel word should do.
  task automatic model_word(input bit ch, input logic [63:0] v, input int n);
    if (!m_aligned) begin
      if (ch) m_aligned = 1;
    end else if (!ch) begin
      m_hold = just(v, n);
      if (n != W) m_err++;
    end else begin
      exp_q.push_back('{m_hold, just(v, n), last_rise});
      if (n != W) m_err++;
    end
  endtask

  // The LSB travels with the next channel's word select (one-bit delay).
  task automatic send_word(input bit ch, input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit((i == 0) ? ~ch : ch, v[i]);
    model_word(ch, v, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 0;
    @(negedge clk);
    rstn = 1;
    m_aligned = 0; m_hold = 0; m_err = 0; fe_seen = 0;
    exp_q.delete(); obs_q.delete();
    check("rst_left", left_data, 0);
    check("rst_right", right_data, 0);
    check("rst_valid", {63'd0, valid}, 0);
    check("rst_ferr", {63'd0, frame_err}, 0);
    check("rst_errcnt", err_count, 0);
  endtask

  task automatic drain(input string name);
    int n;
    repeat (12) @(negedge clk);
    check({name, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({name, "_left"}, obs_q[i].l, exp_q[i].l);
      check({name, "_right"}, obs_q[i].r, exp_q[i].r);
      check({name, "_latency_ok"},
            {63'd0, (obs_q[i].c - exp_q[i].c >= S + 1) && (obs_q[i].c - exp_q[i].c <= S + 2)}, 1);
      if (bb_mode && i > 0) check({name, "_gap"}, obs_q[i].c - obs_q[i-1].c, 384);
    end
    check({name, "_ferr_pulses"}, fe_seen, m_err);
`ifdef I2S_RX_ERRCNT_EN
    check({name, "_errcnt"}, err_count, m_err);
`else
    check({name, "_errcnt"}, err_count, 0);
`endif
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    // Clean frame after one alignment frame.
    do_reset();
    send_word(0, 64'h111111, 24);
    send_word(1, 64'h222222, 24);
    send_word(0, 64'hABCDEF, 24);
    send_word(1, 64'h123456, 24);
    drain("clean");
    check("clean_lit_left", left_data, 24'hABCDEF);
    check("clean_lit_right", right_data, 24'h123456);

    // Stream starts mid-right-word: partial word must not publish.
    do_reset();
    send_word(1, 64'h3FF, 10);
    send_word(0, 64'h0F0F0F, 24);
    send_word(1, 64'hF0F0F0, 24);
    drain("midright");

    // Short 20-bit words are left-justified and flagged.
    do_reset();
    send_word(1, 64'h0, 24);
    send_word(0, 64'hFFFFF, 20);
    send_word(1, 64'h00001, 20);
    drain("short20");
    check("short_lit_left", left_data, 24'hFFFFF0);
    check("short_lit_right", right_data, 24'h000010);

    // Long 26-bit words: surplus LSBs discarded, flagged.
    send_word(0, 64'h2000007, 26);
    send_word(1, 64'h1FFFFF9, 26);
    drain("long26");
    check("long_lit_left", left_data, 24'h800001);
    check("long_lit_right", right_data, 24'h7FFFFE);

    // Reset mid-left-word: partial bits must not leak into the next pair.
    send_word(0, 64'h111111, 24);
    send_word(1, 64'h222222, 24);
    drain("prereset");
    for (int i = 23; i >= 14; i--) send_bit(0, i[0]);
    do_reset();
    for (int i = 13; i >= 0; i--) send_bit((i == 0) ? 1'b1 : 1'b0, i[0]);
    model_word(0, 64'hAAAAAA, 24);
    send_word(1, 64'h0, 24);
    send_word(0, 64'h135790, 24);
    send_word(1, 64'h24680A, 24);
    drain("midreset");
    check("midreset_lit_left", left_data, 24'h135790);

    // 100 back-to-back frames of incrementing data.
    do_reset();
    bb_mode = 1;
    send_word(1, 64'h0, 24);
    for (int f = 0; f < 100; f++) begin
      send_word(0, 64'(f), 24);
      send_word(1, 64'(f + 24'h800000), 24);
    end
    drain("b2b");
    bb_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
